icache_fetch_responder: RTL and testbench
=========================================

Name: icache_fetch_responder

Overview:
- Instruction-side responder on the fetch interface driven by the instruction fetch/issue unit.
- Direct-mapped, read-only instruction cache with halfword granularity, so 2-byte-aligned (RVC) PCs work.
- Answers hits combinationally in the same cycle. Refills missing lines byte-serially from the memory arbiter.

Parameters:
- INDEX_BIT, 4, log2 of the number of cache lines.
- LINE_BIT, 4, log2 of bytes per line (16 B; minimum 2).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes all state.
- clear  in  1  ROB flush; suppresses this cycle's response.
- inst_req  in  1  fetch request from the fetch unit.
- pc  in  32  fetch address, bit0 ignored (halfword aligned).
- inst_ready  out  1  inst valid this cycle for pc.
- inst  out  32  {hw(pc+2), hw(pc)}.
- mem_busy  out  1  refill in progress.
- mem_req  out  1  byte read request to the arbiter.
- mem_addr  out  32  byte address of the request.
- mem_gnt  in  1  arbiter accepts mem_addr this cycle.
- mem_rvalid  in  1  mem_rdata valid; always exactly 1 cycle after a granted request.
- mem_rdata  in  8  returned byte.

Behaviour:
- Storage: 2^INDEX_BIT lines, each with a valid bit, tag = pc[31:INDEX_BIT+LINE_BIT] and 2^LINE_BIT bytes.
- Lookup:
  - L0 = line(pc); L1 = line(pc+2).
  - hit0 = valid & tag match on L0; hit1 likewise on L1.
  - L1 == L0 unless pc sits on the last halfword of a line.
- Compressed test: cmp = hw(pc)[1:0] != 2'b11.
- inst_ready = inst_req & rdy_in & !clear & state==IDLE & hit0 & (cmp | hit1). Purely combinational.
- inst is combinational and undefined when inst_ready=0. When cmp=1 and L1 misses, inst[31:16] is don't-care.
- FSM states: IDLE, FILL.
- IDLE -> FILL when inst_req & rdy_in & !clear & miss:
  - Fill base = L0 if !hit0, else L1 (when !cmp & !hit1), with the line offset bits zeroed.
  - Latch base; set issue_cnt = 0 and recv_cnt = 0.
- In FILL:
  - mem_req = (issue_cnt < 2^LINE_BIT); mem_addr = base + issue_cnt.
  - issue_cnt increments on each mem_req & mem_gnt.
  - Each mem_rvalid writes mem_rdata to byte recv_cnt of a staging line; recv_cnt increments.
  - Addresses are sequential, up to one per cycle. mem_gnt gaps are legal.
- FILL -> IDLE on the cycle recv_cnt reaches 2^LINE_BIT:
  - Staging line, tag and valid=1 are written to the indexed line on that clock edge (overwriting any previous line there).
  - The re-presented pc hits next cycle, or triggers the second-line fill for a straddling 32-bit instruction.
- mem_busy = (state == FILL). Both inst_ready and mem_busy are low in FILL.
- mem_rvalid while in IDLE is ignored.
- clear during FILL:
  - The fill runs to completion and the line is installed (outstanding reads cannot be cancelled).
  - inst_ready stays 0 in any cycle where clear=1.
  - clear in IDLE blocks starting a new fill that cycle.
- rdy_in=0: FSM, counters and arrays hold; mem_req=0; issue_cnt is not incremented; inst_ready=0. mem_rvalid data arriving during rdy_in=0 is still captured (the read was already granted).
- Reset (asynchronous, any time including mid-fill): all valid bits=0, state=IDLE, counters=0. Outputs inst_ready=0, mem_busy=0, mem_req=0, mem_addr=0.
- Counter widths are LINE_BIT+1 bits. Address arithmetic is 32-bit wrapping (pc=0xFFFFFFFE makes L1 line 0).

Test Plan:
- Cold miss: reset release, inst_req=1, pc=0x0000_0010; memory returns bytes 0x10..0x1F with mem_gnt=1 every cycle -> mem_addr sweeps 0x10..0x1F over 16 consecutive cycles; mem_busy high until the 17th rvalid-complete edge; next cycle inst_ready=1 and inst={byte13,byte12,byte11,byte10}.
- Straddle: lines 0x10 and 0x20 cold, pc=0x1E, hw(0x1E)[1:0]=2'b11 -> line 0x10 filled, then line 0x20 filled; inst_ready only after both, inst={mem[0x21..0x20], mem[0x1F..0x1E]}.
- Compressed straddle: pc=0x1E, hw(0x1E)[1:0]=2'b01, line 0x10 valid, line 0x20 cold -> inst_ready=1 the same cycle, no fill started.
- Grant gaps and rdy_in: mem_gnt toggles 1,0,1,0 and rdy_in=0 for 3 cycles mid-fill -> no address skipped or repeated; the installed line matches memory byte-for-byte.
- Clear mid-fill: clear pulse at byte 5 of a fill for pc=0x40 -> all 16 bytes still fetched, line valid; clear=1 with pc=0x40 afterwards gives inst_ready=0; clear=0 gives inst_ready=1.
- Async reset mid-fill at byte 7 -> mem_req and mem_busy drop immediately; a previously valid line at pc=0x10 misses after release.

Source files
------------

// File: rtl/icache_fetch_responder.sv
// Direct-mapped read-only I-cache; hits answered combinationally in the same cycle.
// A miss refills one line byte-serially (issue/receive counters) with no fetch response until installed.
module icache_fetch_responder #(
  parameter int INDEX_BIT = 4,
  parameter int LINE_BIT  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        inst_req,
  input  logic [31:0] pc,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        mem_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata
);
  localparam int LINES = 1 << INDEX_BIT;
  localparam int BYTES = 1 << LINE_BIT;
  localparam int TAG_W = 32 - INDEX_BIT - LINE_BIT;
  localparam int LW    = 8 * BYTES;

  typedef enum logic [0:0] {IDLE, FILL} state_t;

  state_t                 state_q, state_d;
  logic [LINE_BIT:0]      issue_q, issue_d;
  logic [LINE_BIT:0]      recv_q, recv_d;
  logic [31:0]            base_q, base_d;
  logic [LW-1:0]          stage_q, stage_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [LW-1:0]          data_q [LINES];
  logic                   install;

  logic [31:0]            pc0, pc1, fill_sel;
  logic [INDEX_BIT-1:0]   idx0, idx1, base_idx;
  logic [LINE_BIT-1:0]    off0, off1;
  logic                   hit0, hit1, cmp, miss;
  logic [15:0]            hw0, hw1;

  // pc1 wraps at 32 bits, so the last halfword of memory looks up line 0
  assign pc0      = pc & ~32'd1;
  assign pc1      = pc0 + 32'd2;
  assign idx0     = pc0[INDEX_BIT+LINE_BIT-1:LINE_BIT];
  assign idx1     = pc1[INDEX_BIT+LINE_BIT-1:LINE_BIT];
  assign off0     = pc0[LINE_BIT-1:0];
  assign off1     = pc1[LINE_BIT-1:0];
  assign hit0     = valid_q[idx0] && (tag_q[idx0] == pc0[31:INDEX_BIT+LINE_BIT]);
  assign hit1     = valid_q[idx1] && (tag_q[idx1] == pc1[31:INDEX_BIT+LINE_BIT]);
  assign hw0      = data_q[idx0][{off0, 3'b000} +: 16];
  assign hw1      = data_q[idx1][{off1, 3'b000} +: 16];
  assign cmp      = (hw0[1:0] != 2'b11);
  assign miss     = !hit0 || (!cmp && !hit1);
  assign fill_sel = hit0 ? pc1 : pc0;
  assign base_idx = base_q[INDEX_BIT+LINE_BIT-1:LINE_BIT];

  assign mem_busy   = (state_q == FILL);
  assign mem_req    = mem_busy && rdy_in && !issue_q[LINE_BIT];
  assign mem_addr   = mem_busy ? base_q + {{(31-LINE_BIT){1'b0}}, issue_q} : 32'd0;
  assign inst_ready = inst_req && rdy_in && !clear && !mem_busy && hit0 && (cmp || hit1);
  assign inst       = {hw1, hw0};

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    base_d  = base_q;
    stage_d = stage_q;
    valid_d = valid_q;
    install = 1'b0;
    // Returned bytes are captured even while frozen: the read was already granted
    if (state_q == FILL && mem_rvalid && !recv_q[LINE_BIT]) begin
      stage_d[{recv_q[LINE_BIT-1:0], 3'b000} +: 8] = mem_rdata;
      recv_d = recv_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (inst_req && rdy_in && !clear && miss) begin
          state_d = FILL;
          base_d  = {fill_sel[31:LINE_BIT], {LINE_BIT{1'b0}}};
          issue_d = '0;
          recv_d  = '0;
        end
      end
      FILL: begin
        if (rdy_in) begin
          if (mem_req && mem_gnt) issue_d = issue_q + 1'b1;
          if (recv_d[LINE_BIT]) begin
            state_d           = IDLE;
            install           = 1'b1;
            valid_d[base_idx] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      issue_q <= '0;
      recv_q  <= '0;
      base_q  <= '0;
      stage_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      base_q  <= base_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: valid bits gate every use
  always_ff @(posedge clk_in) begin
    if (install) begin
      tag_q[base_idx]  <= base_q[31:INDEX_BIT+LINE_BIT];
      data_q[base_idx] <= stage_d;
    end
  end
endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder with a byte-wide memory model answering one cycle after grant.
module tb_icache_fetch_responder;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, inst_req;
  logic [31:0] pc;
  logic        inst_ready, mem_busy, mem_req;
  logic [31:0] inst, mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [256];
  logic [31:0] exp_addr;
  int          n_chk = 0;
  int          n_fail = 0;

  icache_fetch_responder #(.INDEX_BIT(4), .LINE_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .inst_req(inst_req), .pc(pc), .inst_ready(inst_ready), .inst(inst),
    .mem_busy(mem_busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called in the low phase with inputs set; returns at the next negedge
  task automatic tick();
    logic        g;
    logic [31:0] a;
    #1;
    g = mem_req & mem_gnt;
    a = mem_addr;
    if (g) begin
      chk("mem_addr_seq", a, exp_addr);
      exp_addr = exp_addr + 32'd1;
    end
    @(posedge clk_in);
    @(negedge clk_in);
    mem_rvalid = g;
    mem_rdata  = mem[a[7:0]];
  endtask

  task automatic do_reset();
    rst_in     = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic run_fill(input logic [31:0] base);
    exp_addr = base;
    tick();
    chk("fill_start", {31'd0, mem_busy}, 32'd1);
    for (int n = 0; n < 60 && mem_busy; n++) tick();
    chk("fill_done", {31'd0, mem_busy}, 32'd0);
    chk("fill_count", exp_addr, base + 32'd16);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem[a[7:0]+8'd3], mem[a[7:0]+8'd2], mem[a[7:0]+8'd1], mem[a[7:0]]};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; inst_req = 1'b1; pc = 32'h10;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 8'h00; exp_addr = 32'h0;
    @(negedge clk_in);
    #1;
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("rst_mem_busy", {31'd0, mem_busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Cold miss with exact timing
    #1;
    chk("cold_miss", {31'd0, inst_ready}, 32'd0);
    exp_addr = 32'h10;
    tick();
    chk("cold_busy", {31'd0, mem_busy}, 32'd1);
    chk("cold_first_addr", mem_addr, 32'h10);
    repeat (16) tick();
    chk("cold_busy_16", {31'd0, mem_busy}, 32'd1);
    tick();
    chk("cold_busy_17", {31'd0, mem_busy}, 32'd0);
    #1;
    chk("cold_ready", {31'd0, inst_ready}, 32'd1);
    chk("cold_inst", inst, 32'h1312_1110);

    // 32-bit instruction straddling two cold lines
    mem[8'h1E] = 8'h1F;
    do_reset();
    pc = 32'h1E;
    run_fill(32'h10);
    #1;
    chk("straddle_wait", {31'd0, inst_ready}, 32'd0);
    run_fill(32'h20);
    #1;
    chk("straddle_ready", {31'd0, inst_ready}, 32'd1);
    chk("straddle_inst", inst, 32'h2120_1F1F);

    // Compressed instruction on the last halfword: no second-line fill
    mem[8'h1E] = 8'h1D;
    do_reset();
    pc = 32'h10;
    run_fill(32'h10);
    pc = 32'h1E;
    #1;
    chk("cmp_ready", {31'd0, inst_ready}, 32'd1);
    chk("cmp_hw0", {16'd0, inst[15:0]}, 32'h0000_1F1D);
    tick();
    chk("cmp_no_fill", {31'd0, mem_busy}, 32'd0);

    // Grant gaps and a 3-cycle rdy_in freeze mid-fill
    pc = 32'h30;
    exp_addr = 32'h30;
    tick();
    for (int i = 0; i < 80 && mem_busy; i++) begin
      mem_gnt = (i % 2 == 0);
      rdy_in  = !(i >= 6 && i < 9);
      tick();
    end
    mem_gnt = 1'b1;
    rdy_in  = 1'b1;
    chk("gap_done", {31'd0, mem_busy}, 32'd0);
    chk("gap_count", exp_addr, 32'h40);
    for (int k = 0; k < 4; k++) begin
      pc = 32'h30 + 32'(4 * k);
      #1;
      chk("gap_ready", {31'd0, inst_ready}, 32'd1);
      chk("gap_word", inst, word_at(pc));
    end
    rdy_in = 1'b0;
    #1;
    chk("rdy_low_ready", {31'd0, inst_ready}, 32'd0);
    rdy_in = 1'b1;

    // clear pulse mid-fill still completes and installs the line
    pc = 32'h40;
    exp_addr = 32'h40;
    tick();
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int n = 0; n < 60 && mem_busy; n++) tick();
    chk("clr_done", {31'd0, mem_busy}, 32'd0);
    chk("clr_count", exp_addr, 32'h50);
    clear = 1'b1;
    #1;
    chk("clr_blocks_ready", {31'd0, inst_ready}, 32'd0);
    clear = 1'b0;
    #1;
    chk("clr_release_ready", {31'd0, inst_ready}, 32'd1);
    chk("clr_inst", inst, 32'h4342_4140);

    // clear in IDLE blocks a new fill
    pc = 32'h50;
    clear = 1'b1;
    tick();
    chk("clr_idle_no_fill", {31'd0, mem_busy}, 32'd0);
    clear = 1'b0;

    // Async reset mid-fill
    pc = 32'h10;
    #1;
    chk("pre_rst_hit", {31'd0, inst_ready}, 32'd1);
    pc = 32'h60;
    exp_addr = 32'h60;
    tick();
    repeat (7) tick();
    chk("pre_rst_busy", {31'd0, mem_busy}, 32'd1);
    rst_in = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_mem_busy", {31'd0, mem_busy}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    pc = 32'h10;
    #1;
    chk("post_rst_miss", {31'd0, inst_ready}, 32'd0);
    exp_addr = 32'h10;
    tick();
    chk("post_rst_refill", {31'd0, mem_busy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
